// File: rtl/debug_pkg.sv
// Shared definitions for the host-side debug controller: command bytes,
// the HALT instruction word and the FSM / dump-section encodings.
package debug_pkg;

  localparam logic [7:0]  CMD_LOAD  = 8'h4C;
  localparam logic [7:0]  CMD_RUN   = 8'h52;
  localparam logic [7:0]  CMD_STEP  = 8'h53;
  localparam logic [7:0]  CMD_DUMP  = 8'h44;
  localparam logic [31:0] HALT_WORD = 32'h0000_003F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_STEP,
    ST_DUMP_ADDR,
    ST_DUMP_LATCH,
    ST_DUMP_SEND,
    ST_DUMP_WAIT
  } state_e;

  typedef enum logic [1:0] {
    DUMP_PC,
    DUMP_REG,
    DUMP_MEM
  } section_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SEND,
    SER_WAIT
  } ser_state_e;

endpackage

// File: rtl/debug_word_serializer.sv
// Latches one word and sends it MSB-first as bytes over a start/done
// UART TX handshake; pulses done_o after the last byte is acknowledged.
module debug_word_serializer
  import debug_pkg::*;
#(
  parameter int unsigned WORD_SZ = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [WORD_SZ-1:0] word_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_start_o,
  input  logic               tx_done_i,
  output logic               done_o
);

  localparam int unsigned NB = WORD_SZ / 8;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  ser_state_e         state_q, state_d;
  logic [WORD_SZ-1:0] shift_q, shift_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SER_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_start_o = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (load_i) begin
          shift_d = word_i;
          cnt_d   = '0;
          state_d = SER_SEND;
        end
      end
      SER_SEND: begin
        tx_start_o = 1'b1;
        state_d    = SER_WAIT;
      end
      SER_WAIT: begin
        // tx_done only counts here, so a stray ack can never trigger a resend
        if (tx_done_i) begin
          if (cnt_q == CW'(NB - 1)) begin
            done_o  = 1'b1;
            state_d = SER_IDLE;
          end else begin
            shift_d = shift_q << 8;
            cnt_d   = cnt_q + CW'(1);
            state_d = SER_SEND;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  assign tx_data_o = shift_q[WORD_SZ-1 -: 8];

endmodule

// File: rtl/debug_unit.sv
// Host-side load/run/step/dump controller for the pipeline, driven by a
// UART RX byte stream and dumping PC, GPRs and DMEM over UART TX.
module debug_unit
  import debug_pkg::*;
#(
  parameter int unsigned INST_SZ     = 32,
  parameter int unsigned DBG_ADDR_SZ = 5,
  parameter int unsigned N_REGS      = 32,
  parameter int unsigned MEM_WORDS   = 32,
  parameter int unsigned IMEM_WORDS  = 64
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_done,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_write,
  output logic [INST_SZ-1:0]     o_instruction,
  output logic                   o_enable,
  output logic [DBG_ADDR_SZ-1:0] o_debug_addr,
  input  logic [INST_SZ-1:0]     i_pc,
  input  logic [INST_SZ-1:0]     i_reg,
  input  logic [INST_SZ-1:0]     i_mem,
  input  logic                   i_halt
);

  localparam int unsigned NB  = INST_SZ / 8;
  localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned WCW = $clog2(IMEM_WORDS + 1);

  state_e                   state_q, state_d;
  section_e                 sec_q, sec_d;
  logic [DBG_ADDR_SZ-1:0]   addr_q, addr_d;
  logic [BCW-1:0]           bcnt_q, bcnt_d;
  logic [WCW-1:0]           wcnt_q, wcnt_d;
  logic [INST_SZ-1:0]       word_q, word_d;
  logic [INST_SZ-1:0]       instr_q, instr_d;
  logic                     write_q, write_d;
  logic                     enable_q, enable_d;
  logic                     start_dump;
  logic                     ser_load, ser_done;
  logic [INST_SZ-1:0]       ser_word;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      sec_q    <= DUMP_PC;
      addr_q   <= '0;
      bcnt_q   <= '0;
      wcnt_q   <= '0;
      word_q   <= '0;
      instr_q  <= '0;
      write_q  <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sec_q    <= sec_d;
      addr_q   <= addr_d;
      bcnt_q   <= bcnt_d;
      wcnt_q   <= wcnt_d;
      word_q   <= word_d;
      instr_q  <= instr_d;
      write_q  <= write_d;
      enable_q <= enable_d;
    end
  end

  always_comb begin
    case (sec_q)
      DUMP_PC:  ser_word = i_pc;
      DUMP_REG: ser_word = i_reg;
      default:  ser_word = i_mem;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sec_d      = sec_q;
    addr_d     = addr_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    word_d     = word_q;
    instr_d    = instr_q;
    write_d    = 1'b0;
    enable_d   = 1'b0;
    start_dump = 1'b0;
    ser_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_d = ST_LOAD;
              bcnt_d  = '0;
              wcnt_d  = '0;
              word_d  = '0;
            end
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            CMD_DUMP: start_dump = 1'b1;
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        if (i_rx_done) begin
          word_d = {word_q[INST_SZ-9:0], i_rx_data};
          if (bcnt_q == BCW'(NB - 1)) begin
            bcnt_d  = '0;
            write_d = 1'b1;
            instr_d = word_d;
            wcnt_d  = wcnt_q + WCW'(1);
            if (word_d == INST_SZ'(HALT_WORD) || wcnt_q == WCW'(IMEM_WORDS - 1))
              state_d = ST_IDLE;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end
      end
      ST_RUN: begin
        if (i_halt) start_dump = 1'b1;
        else        enable_d   = 1'b1;
      end
      ST_STEP: begin
        // Stay one extra cycle so the single enable pulse ends before DUMP begins
        if (enable_q || i_halt) start_dump = 1'b1;
        else                    enable_d   = 1'b1;
      end
      ST_DUMP_ADDR:  state_d = ST_DUMP_LATCH;
      ST_DUMP_LATCH: begin
        ser_load = 1'b1;
        state_d  = ST_DUMP_SEND;
      end
      ST_DUMP_SEND:  state_d = ST_DUMP_WAIT;
      ST_DUMP_WAIT: begin
        if (ser_done) begin
          state_d = ST_DUMP_ADDR;
          case (sec_q)
            DUMP_PC: begin
              sec_d  = DUMP_REG;
              addr_d = '0;
            end
            DUMP_REG: begin
              if (addr_q == DBG_ADDR_SZ'(N_REGS - 1)) begin
                sec_d  = DUMP_MEM;
                addr_d = '0;
              end else begin
                addr_d = addr_q + DBG_ADDR_SZ'(1);
              end
            end
            default: begin
              if (addr_q == DBG_ADDR_SZ'(MEM_WORDS - 1) || addr_q == '1)
                state_d = ST_IDLE;
              else
                addr_d = addr_q + DBG_ADDR_SZ'(1);
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_dump) begin
      state_d = ST_DUMP_ADDR;
      sec_d   = DUMP_PC;
      addr_d  = '0;
    end
  end

  debug_word_serializer #(
    .WORD_SZ(INST_SZ)
  ) u_ser (
    .clk_i     (i_clk),
    .rst_i     (i_reset),
    .load_i    (ser_load),
    .word_i    (ser_word),
    .tx_data_o (o_tx_data),
    .tx_start_o(o_tx_start),
    .tx_done_i (i_tx_done),
    .done_o    (ser_done)
  );

  assign o_write       = write_q;
  assign o_instruction = instr_q;
  assign o_enable      = enable_q;
  assign o_debug_addr  = addr_q;

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: table-driven load vectors plus
// hand-written run/step/dump sequences against a UART TX responder.
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_done = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done = 1'b0;
  logic        o_write;
  logic [31:0] o_instruction;
  logic        o_enable;
  logic [4:0]  o_debug_addr;
  logic [31:0] i_pc;
  logic [31:0] i_reg;
  logic [31:0] i_mem;
  logic        i_halt = 1'b0;

  logic [31:0] reg_m [32];
  logic [31:0] mem_m [32];
  localparam logic [31:0] PC_VAL = 32'h0000_0124;
  localparam int unsigned DUMP_BYTES = 260;

  always #5 clk = ~clk;

  assign i_pc  = PC_VAL;
  assign i_reg = reg_m[o_debug_addr];
  assign i_mem = mem_m[o_debug_addr];

  debug_unit #(
    .INST_SZ(32), .DBG_ADDR_SZ(5), .N_REGS(32), .MEM_WORDS(32), .IMEM_WORDS(64)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_write(o_write), .o_instruction(o_instruction), .o_enable(o_enable),
    .o_debug_addr(o_debug_addr), .i_pc(i_pc), .i_reg(i_reg), .i_mem(i_mem),
    .i_halt(i_halt)
  );

  int unsigned n_cmp = 0, n_err = 0;
  int unsigned wr_cnt = 0, en_cnt = 0, overlap = 0, tx_delay = 0, cd = 0;
  logic        pending = 1'b0;
  logic [31:0] last_instr = '0;
  logic [7:0]  tx_q [$];

  // Output monitor and UART TX responder
  initial begin
    forever begin
      @(negedge clk);
      if (o_write) begin
        wr_cnt++;
        last_instr = o_instruction;
      end
      if (o_enable) en_cnt++;
      if (o_tx_start && pending) overlap++;
      i_tx_done = 1'b0;
      if (pending) begin
        if (cd == 0) begin
          i_tx_done = 1'b1;
          pending   = 1'b0;
        end else cd--;
      end
      if (o_tx_start) begin
        tx_q.push_back(o_tx_data);
        pending = 1'b1;
        cd      = tx_delay;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  function automatic logic [7:0] exp_byte(input int unsigned idx);
    logic [31:0] w;
    int unsigned wi;
    wi = idx / 4;
    if (wi == 0)       w = PC_VAL;
    else if (wi <= 32) w = reg_m[wi-1];
    else               w = mem_m[wi-33];
    return w[31 - 8*(idx % 4) -: 8];
  endfunction

  task automatic wait_bytes(input string name, input int unsigned target);
    int unsigned budget;
    budget = DUMP_BYTES * (tx_delay + 8) + 200;
    for (int unsigned c = 0; c < budget && tx_q.size() < target; c++) @(negedge clk);
    repeat (tx_delay + 30) @(negedge clk);
    check({name, "_len"}, tx_q.size(), target);
  endtask

  task automatic check_dump(input string name, input int unsigned start);
    int unsigned bad;
    logic [7:0]  got, want;
    bad = DUMP_BYTES;
    got = '0;
    want = '0;
    for (int unsigned i = 0; i < DUMP_BYTES; i++) begin
      if (bad == DUMP_BYTES) begin
        want = exp_byte(i);
        got  = (start + i < tx_q.size()) ? tx_q[start+i] : 8'hxx;
        if (got !== want) bad = i;
      end
    end
    n_cmp++;
    if (bad != DUMP_BYTES) begin
      n_err++;
      $display("FAIL %s: byte %0d got %h expected %h", name, bad, got, want);
    end
  endtask

  typedef struct {
    logic [7:0]  rx;
    int unsigned exp_writes;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs [20];

  initial begin
    int unsigned s, en0, wr0, k;

    for (int unsigned i = 0; i < 32; i++) begin
      reg_m[i] = 32'h1000_0000 + i * 32'h0000_0101;
      mem_m[i] = 32'hC000_0000 | (i << 8) | i;
    end
    reg_m[10] = 32'h0000_0004;

    vecs[0]  = '{8'h4C, 0, 32'h0};
    vecs[1]  = '{8'h20, 0, 32'h0};
    vecs[2]  = '{8'h02, 0, 32'h0};
    vecs[3]  = '{8'h00, 0, 32'h0};
    vecs[4]  = '{8'h02, 1, 32'h2002_0002};
    vecs[5]  = '{8'h00, 1, 32'h2002_0002};
    vecs[6]  = '{8'h00, 1, 32'h2002_0002};
    vecs[7]  = '{8'h00, 1, 32'h2002_0002};
    vecs[8]  = '{8'h3F, 2, 32'h0000_003F};
    vecs[9]  = '{8'h02, 2, 32'h0000_003F};
    vecs[10] = '{8'h41, 2, 32'h0000_003F};
    vecs[11] = '{8'h4C, 2, 32'h0000_003F};
    vecs[12] = '{8'hDE, 2, 32'h0000_003F};
    vecs[13] = '{8'hAD, 2, 32'h0000_003F};
    vecs[14] = '{8'hBE, 2, 32'h0000_003F};
    vecs[15] = '{8'hEF, 3, 32'hDEAD_BEEF};
    vecs[16] = '{8'h00, 3, 32'hDEAD_BEEF};
    vecs[17] = '{8'h00, 3, 32'hDEAD_BEEF};
    vecs[18] = '{8'h00, 3, 32'hDEAD_BEEF};
    vecs[19] = '{8'h3F, 4, 32'h0000_003F};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_start", {31'b0, o_tx_start}, 32'h0);
    check("rst_write", {31'b0, o_write}, 32'h0);
    check("rst_enable", {31'b0, o_enable}, 32'h0);
    check("rst_addr_instr", {o_debug_addr, o_instruction[26:0]}, 32'h0);
    i_reset = 1'b0;
    @(negedge clk);

    // Load vectors
    for (int unsigned v = 0; v < 20; v++) begin
      send_rx(vecs[v].rx);
      @(negedge clk);
      check($sformatf("load%0d_writes", v), wr_cnt, vecs[v].exp_writes);
      check($sformatf("load%0d_instr", v), last_instr, vecs[v].exp_instr);
    end

    // Reset aborts a partial word
    wr0 = wr_cnt;
    send_rx(8'h4C); send_rx(8'h20); send_rx(8'h02); send_rx(8'h00);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    s = tx_q.size();
    send_rx(8'h44);
    wait_bytes("abort_dump", s + DUMP_BYTES);
    check("abort_writes", wr_cnt, wr0);
    check_dump("abort_stream", s);

    // Run until halt after 20 enabled cycles
    en0 = en_cnt;
    s = tx_q.size();
    send_rx(8'h52);
    k = 0;
    for (int unsigned c = 0; c < 200 && k < 20; c++) begin
      @(negedge clk);
      if (o_enable) k++;
    end
    i_halt = 1'b1;
    check("run_enable_seen", k, 20);
    wait_bytes("run_dump", s + DUMP_BYTES);
    check("run_enable_total", en_cnt - en0, 20);
    check_dump("run_stream", s);
    i_halt = 1'b0;

    // Step, not halted
    en0 = en_cnt;
    s = tx_q.size();
    send_rx(8'h53);
    wait_bytes("step_dump", s + DUMP_BYTES);
    check("step_enable", en_cnt - en0, 1);
    check_dump("step_stream", s);

    // Step while halted
    i_halt = 1'b1;
    en0 = en_cnt;
    s = tx_q.size();
    send_rx(8'h53);
    wait_bytes("step_halt_dump", s + DUMP_BYTES);
    check("step_halt_enable", en_cnt - en0, 0);
    check_dump("step_halt_stream", s);
    i_halt = 1'b0;

    // Dump with slow transmitter
    tx_delay = 50;
    s = tx_q.size();
    send_rx(8'h44);
    wait_bytes("slow_dump", s + DUMP_BYTES);
    check("slow_reg10", {tx_q[s+44], tx_q[s+45], tx_q[s+46], tx_q[s+47]}, 32'h0000_0004);
    check_dump("slow_stream", s);
    tx_delay = 0;

    // Bytes received mid-dump are ignored
    en0 = en_cnt;
    wr0 = wr_cnt;
    s = tx_q.size();
    send_rx(8'h44);
    for (int unsigned c = 0; c < 500 && tx_q.size() < s + 10; c++) @(negedge clk);
    send_rx(8'h41); send_rx(8'h4C); send_rx(8'h52); send_rx(8'h53); send_rx(8'h00);
    wait_bytes("perturb_dump", s + DUMP_BYTES);
    check_dump("perturb_stream", s);
    check("perturb_writes", wr_cnt, wr0);
    check("perturb_enable", en_cnt - en0, 0);

    check("tx_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
